// File: rtl/pipeline_control_arbiter_pkg.sv
// Shared types for the pipeline control request interface: the control word
// that every requester drives, the arbiter FSM encoding and small field helpers.
package pipeline_control_arbiter_pkg;

  localparam int unsigned NUM_BARRIERS           = 4;
  localparam int unsigned NUM_REQUESTERS_DEFAULT = 4;

  // Barrier order used by the helper vectors: bit 0 = IF/ID, 1 = ID/EX,
  // 2 = EX/MEM, 3 = MEM/WB.
  typedef struct packed {
    logic active;
    logic exclusive;
    logic stage_IF_stall;
    logic stage_ID_stall;
    logic stage_EX_stall;
    logic stage_MEM_stall;
    logic stage_WB_stall;
    logic barrier_IF_ID_stall;
    logic barrier_ID_EX_stall;
    logic barrier_EX_MEM_stall;
    logic barrier_MEM_WB_stall;
    logic barrier_IF_ID_reset;
    logic barrier_ID_EX_reset;
    logic barrier_EX_MEM_reset;
    logic barrier_MEM_WB_reset;
  } lc3b_pipeline_control_word;

  localparam lc3b_pipeline_control_word PIPELINE_CONTROL_IDLE = '0;

  typedef logic [$clog2(NUM_REQUESTERS_DEFAULT)-1:0] lc3b_requester_id;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Field-wise merge of two control words.
  function automatic lc3b_pipeline_control_word control_word_or(
    input lc3b_pipeline_control_word a,
    input lc3b_pipeline_control_word b
  );
    return a | b;
  endfunction

  function automatic logic [NUM_BARRIERS-1:0] barrier_stall_bits(
    input lc3b_pipeline_control_word w
  );
    return {w.barrier_MEM_WB_stall, w.barrier_EX_MEM_stall,
            w.barrier_ID_EX_stall, w.barrier_IF_ID_stall};
  endfunction

  function automatic logic [NUM_BARRIERS-1:0] barrier_reset_bits(
    input lc3b_pipeline_control_word w
  );
    return {w.barrier_MEM_WB_reset, w.barrier_EX_MEM_reset,
            w.barrier_ID_EX_reset, w.barrier_IF_ID_reset};
  endfunction

  function automatic lc3b_pipeline_control_word with_barrier_resets(
    input lc3b_pipeline_control_word w,
    input logic [NUM_BARRIERS-1:0]   resets
  );
    lc3b_pipeline_control_word r;
    r                      = w;
    r.barrier_IF_ID_reset  = resets[0];
    r.barrier_ID_EX_reset  = resets[1];
    r.barrier_EX_MEM_reset = resets[2];
    r.barrier_MEM_WB_reset = resets[3];
    return r;
  endfunction

endpackage

// File: rtl/pipeline_control_arbiter_merge.sv
// Combinational OR-reduction of the granted requests into one control word.
module pipeline_control_merge
  import pipeline_control_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  lc3b_pipeline_control_word [NUM_REQUESTERS-1:0] request_in,
  input  logic [NUM_REQUESTERS-1:0]                      grant,
  output lc3b_pipeline_control_word                      merged
);

  // Accumulate every granted request field by field.
  always_comb begin
    merged = PIPELINE_CONTROL_IDLE;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant[i]) begin
        merged = control_word_or(merged, request_in[i]);
      end
    end
  end

endmodule

// File: rtl/pipeline_control_arbiter.sv
// Responder side of the pipeline control request interface: arbitrates
// exclusive ownership, merges granted requests, holds flushes aimed at
// stalled barriers, and keeps two saturating debug counters.
module pipeline_control_arbiter
  import pipeline_control_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  lc3b_pipeline_control_word [NUM_REQUESTERS-1:0] request_in,
  output lc3b_pipeline_control_word                     pipeline_control_out,
  output logic [NUM_REQUESTERS-1:0]                     grant,
  output logic                                          lock_valid,
  output logic [$clog2(NUM_REQUESTERS)-1:0]             lock_owner,
  output logic [CNT_WIDTH-1:0]                          debug_stall_cycles,
  output logic [CNT_WIDTH-1:0]                          debug_flush_count
);

  localparam int unsigned ID_W = $clog2(NUM_REQUESTERS);

  arb_state_e                state_q, state_d;
  logic [ID_W-1:0]           owner_q, owner_d;
  logic                      owner_hold;
  logic                      excl_found;
  logic [ID_W-1:0]           excl_idx;
  logic                      lock_grant;
  lc3b_pipeline_control_word merged;
  lc3b_pipeline_control_word out_word;
  logic [NUM_BARRIERS-1:0]   merged_reset;
  logic [NUM_BARRIERS-1:0]   merged_stall;
  logic [NUM_BARRIERS-1:0]   pending_q;

  // State register: lock state and owner index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Current owner keeps the lock only while still active and exclusive.
  always_comb begin
    owner_hold = 1'b0;
    if (state_q == ARB_LOCKED) begin
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
        if (ID_W'(i) == owner_q) begin
          owner_hold = request_in[i].active & request_in[i].exclusive;
        end
      end
    end
  end

  // Lowest-index active exclusive request, used whenever no lock is held.
  always_comb begin
    excl_found = 1'b0;
    excl_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (!excl_found && request_in[i].active && request_in[i].exclusive) begin
        excl_found = 1'b1;
        excl_idx   = ID_W'(i);
      end
    end
  end

  // Next-state: a dropped lock falls through to IDLE rules in the same cycle,
  // so a new exclusive winner can take over on the very same edge.
  always_comb begin
    state_d = ARB_IDLE;
    owner_d = owner_q;
    if (owner_hold) begin
      state_d = ARB_LOCKED;
    end else if (excl_found) begin
      state_d = ARB_LOCKED;
      owner_d = excl_idx;
    end
  end

  // Output decode: grant vector and whether a lock is granted this cycle.
  always_comb begin
    grant      = '0;
    lock_grant = 1'b0;
    if (!reset) begin
      if (owner_hold) begin
        lock_grant = 1'b1;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
          grant[i] = (ID_W'(i) == owner_q);
        end
      end else if (excl_found) begin
        lock_grant = 1'b1;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
          grant[i] = (ID_W'(i) == excl_idx);
        end
      end else begin
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
          grant[i] = request_in[i].active;
        end
      end
    end
  end

  assign lock_valid = (state_q == ARB_LOCKED);
  assign lock_owner = owner_q;

  pipeline_control_merge #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_merge (
    .request_in(request_in),
    .grant     (grant),
    .merged    (merged)
  );

  assign merged_reset = barrier_reset_bits(merged);
  assign merged_stall = barrier_stall_bits(merged);

  // Final word: exclusive reflects the lock grant, held flushes are replayed
  // on unstalled barriers, and everything is zero in the reset cycle.
  always_comb begin
    out_word           = merged;
    out_word.exclusive = lock_grant;
    out_word           = with_barrier_resets(out_word,
                           merged_reset | (pending_q & ~merged_stall));
    if (reset) begin
      out_word = PIPELINE_CONTROL_IDLE;
    end
  end

  assign pipeline_control_out = out_word;

  // Pending flush: set by reset-while-stalled, held while stalled, dropped
  // after the first unstalled cycle (in which it was forced onto the output).
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= (merged_reset & merged_stall) | (pending_q & merged_stall);
    end
  end

  // Saturating debug counters driven from the final output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      debug_stall_cycles <= '0;
      debug_flush_count  <= '0;
    end else begin
      if (out_word.stage_IF_stall && (debug_stall_cycles != '1)) begin
        debug_stall_cycles <= debug_stall_cycles + 1'b1;
      end
      if (out_word.barrier_IF_ID_reset && (debug_flush_count != '1)) begin
        debug_flush_count <= debug_flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control_arbiter.sv
// Directed bench for pipeline_control_arbiter: a behavioural model checked on
// every cycle plus hand-computed literal expectations at key points.
module tb_pipeline_control_arbiter;
  import pipeline_control_arbiter_pkg::*;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic reset;
  lc3b_pipeline_control_word [N-1:0] req_bus;

  lc3b_pipeline_control_word out_w, out_s;
  logic [N-1:0] grant, grant_s;
  logic         lock_valid, lock_valid_s;
  logic [1:0]   lock_owner, lock_owner_s;
  logic [31:0]  stall_cnt, flush_cnt;
  logic [3:0]   stall_cnt_s, flush_cnt_s;

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  always #5 clk = ~clk;

  pipeline_control_arbiter #(.NUM_REQUESTERS(N), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .request_in(req_bus),
    .pipeline_control_out(out_w), .grant(grant),
    .lock_valid(lock_valid), .lock_owner(lock_owner),
    .debug_stall_cycles(stall_cnt), .debug_flush_count(flush_cnt)
  );

  pipeline_control_arbiter #(.NUM_REQUESTERS(N), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset), .request_in(req_bus),
    .pipeline_control_out(out_s), .grant(grant_s),
    .lock_valid(lock_valid_s), .lock_owner(lock_owner_s),
    .debug_stall_cycles(stall_cnt_s), .debug_flush_count(flush_cnt_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_locked;
  int       m_owner;
  bit [3:0] m_pend;
  int       m_stall, m_flush;

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_cycle();
    int win;
    lc3b_pipeline_control_word e;
    logic [N-1:0] eg;
    bit [3:0] rs, st, ro;
    // registered outputs reflect state before this cycle's edge
    check("lock_valid", 64'(lock_valid), 64'(m_locked));
    check("lock_owner", 64'(lock_owner), 64'(m_owner));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    check("s_lock_valid", 64'(lock_valid_s), 64'(m_locked));
    check("s_stall_cnt", 64'(stall_cnt_s), 64'(sat15(m_stall)));
    check("s_flush_cnt", 64'(flush_cnt_s), 64'(sat15(m_flush)));

    win = -1;
    if (m_locked && req_bus[m_owner].active && req_bus[m_owner].exclusive) win = m_owner;
    else begin
      for (int i = 0; i < N; i++)
        if (win < 0 && req_bus[i].active && req_bus[i].exclusive) win = i;
    end

    e = '0; eg = '0; rs = '0; st = '0;
    if (!reset) begin
      if (win >= 0) begin
        eg[win] = 1'b1;
        e = req_bus[win];
        e.exclusive = 1'b1;
      end else begin
        for (int i = 0; i < N; i++)
          if (req_bus[i].active) begin
            eg[i] = 1'b1;
            e = e | req_bus[i];
          end
        e.exclusive = 1'b0;
      end
      rs = {e.barrier_MEM_WB_reset, e.barrier_EX_MEM_reset, e.barrier_ID_EX_reset, e.barrier_IF_ID_reset};
      st = {e.barrier_MEM_WB_stall, e.barrier_EX_MEM_stall, e.barrier_ID_EX_stall, e.barrier_IF_ID_stall};
      ro = rs | (m_pend & ~st);
      e.barrier_IF_ID_reset  = ro[0];
      e.barrier_ID_EX_reset  = ro[1];
      e.barrier_EX_MEM_reset = ro[2];
      e.barrier_MEM_WB_reset = ro[3];
    end
    check("grant", 64'(grant), 64'(eg));
    check("control_out", 64'(out_w), 64'(e));
    check("s_grant", 64'(grant_s), 64'(eg));
    check("s_control_out", 64'(out_s), 64'(e));

    if (reset) begin
      m_locked = 1'b0; m_owner = 0; m_pend = '0; m_stall = 0; m_flush = 0;
    end else begin
      m_pend   = (m_pend | rs) & st;
      m_locked = (win >= 0);
      if (win >= 0) m_owner = win;
      m_stall += int'(e.stage_IF_stall);
      m_flush += int'(e.barrier_IF_ID_reset);
    end
  endtask

  initial begin
    m_locked = 1'b0; m_owner = 0; m_pend = '0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      model_cycle();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    req_bus = '0;
    req_bus[0].active = 1'b1;
    req_bus[0].stage_IF_stall = 1'b1;
    #2;
    cyc(1);
    #2;
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_out", 64'(out_w), 64'h0);
    cyc(1);

    // Non-exclusive merge of requesters 1 and 2
    reset   = 1'b0;
    req_bus = '0;
    req_bus[1].active = 1'b1;
    req_bus[1].barrier_IF_ID_reset = 1'b1;
    req_bus[1].barrier_ID_EX_reset = 1'b1;
    req_bus[2].active = 1'b1;
    req_bus[2].stage_IF_stall = 1'b1;
    #2;
    check("t1_grant", 64'(grant), 64'b0110);
    check("t1_ifid_rst", 64'(out_w.barrier_IF_ID_reset), 64'd1);
    check("t1_idex_rst", 64'(out_w.barrier_ID_EX_reset), 64'd1);
    check("t1_if_stall", 64'(out_w.stage_IF_stall), 64'd1);
    check("t1_excl", 64'(out_w.exclusive), 64'd0);
    cyc(1);
    #2;
    check("t1_stall_cnt", 64'(stall_cnt), 64'd1);
    check("t1_flush_cnt", 64'(flush_cnt), 64'd1);
    req_bus = '0;
    cyc(1);

    // Requester 2 locks; higher-priority non-exclusive requester 0 denied
    req_bus[2].active = 1'b1;
    req_bus[2].exclusive = 1'b1;
    req_bus[2].stage_IF_stall = 1'b1;
    req_bus[0].active = 1'b1;
    req_bus[0].stage_ID_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("t2_grant", 64'(grant), 64'b0100);
      check("t2_id_stall", 64'(out_w.stage_ID_stall), 64'd0);
      check("t2_excl", 64'(out_w.exclusive), 64'd1);
      if (c > 0) begin
        check("t2_lock_valid", 64'(lock_valid), 64'd1);
        check("t2_lock_owner", 64'(lock_owner), 64'd2);
      end
      cyc(1);
    end
    req_bus = '0;
    cyc(2);

    // Simultaneous exclusive requests 1 and 3; owner hands over without a gap
    req_bus[1].active = 1'b1;
    req_bus[1].exclusive = 1'b1;
    req_bus[1].stage_EX_stall = 1'b1;
    req_bus[3].active = 1'b1;
    req_bus[3].exclusive = 1'b1;
    req_bus[3].stage_MEM_stall = 1'b1;
    #2;
    check("t3_grant_a", 64'(grant), 64'b0010);
    cyc(1);
    #2;
    check("t3_owner_a", 64'(lock_owner), 64'd1);
    check("t3_grant_b", 64'(grant), 64'b0010);
    cyc(1);
    req_bus[1].active = 1'b0;
    #2;
    check("t3_grant_k", 64'(grant), 64'b1000);
    check("t3_mem_stall", 64'(out_w.stage_MEM_stall), 64'd1);
    check("t3_ex_stall", 64'(out_w.stage_EX_stall), 64'd0);
    cyc(1);
    #2;
    check("t3_owner_k", 64'(lock_owner), 64'd3);
    check("t3_valid_k", 64'(lock_valid), 64'd1);
    req_bus = '0;
    cyc(2);

    // Flush requested while ID/EX is stalled is replayed once unstalled
    req_bus[0].active = 1'b1;
    req_bus[0].barrier_ID_EX_reset = 1'b1;
    req_bus[0].barrier_ID_EX_stall = 1'b1;
    #2;
    check("t4_raw", 64'(out_w.barrier_ID_EX_reset), 64'd1);
    cyc(1);
    req_bus[0].barrier_ID_EX_reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      check("t4_stalled", 64'(out_w.barrier_ID_EX_reset), 64'd0);
      cyc(1);
    end
    req_bus = '0;
    #2;
    check("t4_replay", 64'(out_w.barrier_ID_EX_reset), 64'd1);
    cyc(1);
    #2;
    check("t4_after", 64'(out_w.barrier_ID_EX_reset), 64'd0);
    cyc(1);

    // Reset while locked
    req_bus[2].active = 1'b1;
    req_bus[2].exclusive = 1'b1;
    req_bus[2].stage_IF_stall = 1'b1;
    cyc(2);
    #2;
    check("t5_locked", 64'(lock_valid), 64'd1);
    req_bus[0].active = 1'b1;
    req_bus[0].barrier_IF_ID_reset = 1'b1;
    reset = 1'b1;
    #1;
    check("t5_rst_grant", 64'(grant), 64'h0);
    check("t5_rst_out", 64'(out_w), 64'h0);
    cyc(1);
    #2;
    check("t5_unlocked", 64'(lock_valid), 64'd0);
    check("t5_cnt", 64'(stall_cnt), 64'd0);
    check("t5_fcnt", 64'(flush_cnt), 64'd0);
    reset   = 1'b0;
    req_bus = '0;
    cyc(1);

    // Counter saturation on the 4-bit instance
    req_bus[0].active = 1'b1;
    req_bus[0].stage_IF_stall = 1'b1;
    cyc(20);
    #2;
    check("t6_cnt32", 64'(stall_cnt), 64'd20);
    check("t6_cnt4", 64'(stall_cnt_s), 64'd15);
    req_bus = '0;
    cyc(2);

    done = 1'b1;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_control_arbiter.md
Name: pipeline_control_arbiter

Overview:
Responder side of the pipeline control request interface. Collects lc3b_pipeline_control_word requests from every requester (branch controller, hazard detector, cache/memory stall unit, ...) and produces the single merged control word that drives the IF/ID/EX/MEM/WB stages and the four barriers. Owns exclusive-ownership arbitration, and holds flushes (barrier resets) that are requested while the target barrier is stalled. Sits between all requesters and the pipeline datapath.

Parameters:
NUM_REQUESTERS, 4, number of request ports; index 0 has the highest priority.
CNT_WIDTH, 32, width of the debug performance counters.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
request_in  input  NUM_REQUESTERS x lc3b_pipeline_control_word  one request per requester.
pipeline_control_out  output  lc3b_pipeline_control_word  merged control applied to the pipeline.
grant  output  NUM_REQUESTERS  requester i's request is honoured this cycle.
lock_valid  output  1  an exclusive owner currently holds the pipeline.
lock_owner  output  $clog2(NUM_REQUESTERS)  index of the current exclusive owner.
debug_stall_cycles  output  CNT_WIDTH  cycles with stage_IF_stall asserted on the output.
debug_flush_count  output  CNT_WIDTH  cycles with barrier_IF_ID_reset asserted on the output.

Behaviour:
- Request i is active when request_in[i].active = 1. Inactive requests contribute nothing and get grant[i] = 0.
- FSM states:
  - IDLE: no exclusive owner.
    - If one or more active requests have exclusive = 1, the lowest-index one wins.
    - Winner: grant = one-hot(winner). Output = winner's fields only. Next state LOCKED, lock_owner = winner.
    - Otherwise (no exclusive request): grant[i] = active[i]. Output = bitwise OR of all active requests over every field except active and exclusive.
  - LOCKED:
    - Owner still active and exclusive: grant = one-hot(owner). Output = owner's fields only. All other requesters are denied, even higher-priority ones; a lock is never pre-empted.
    - Owner drops active or exclusive: behave as IDLE in that same cycle (no dead cycle) and return to IDLE. A new exclusive winner may lock on that same edge.
- Output active = OR of granted active bits. Output exclusive = lock being granted this cycle.
- Sticky flushes: four pending_reset bits, one per barrier.
  - If the merged barrier_X_reset = 1 and the merged barrier_X_stall = 1 in the same cycle, pending_reset[X] sets.
  - While pending_reset[X] = 1, output barrier_X_reset is forced to 1 in every cycle where barrier_X_stall = 0.
  - pending_reset[X] clears on the edge ending the first cycle with barrier_X_stall = 0.
  - Output barrier_X_reset is raw while stalled; downstream barriers give stall priority.
- Combinational path request_in -> pipeline_control_out and grant: zero latency. Lock and pending state are one-cycle registered.
- Counters:
  - Increment on the conditions listed under Ports.
  - Saturate at all-ones; no wrap.
- Reset: FSM = IDLE, lock_valid = 0, lock_owner = 0, pending_reset = 0, counters = 0.
  - pipeline_control_out = all zero and grant = 0 during the reset cycle, regardless of requests.
- Boundary cases:
  - Simultaneous exclusive requests: lowest index wins; the others retry.
  - Exclusive request while unlocked and with non-exclusive requests active: non-exclusive requests are denied that cycle.
  - Reset asserted mid-lock: the lock is dropped immediately.

Decomposition:
- lc3b_types: add lc3b_pipeline_control_word field-merge helper constant PIPELINE_CONTROL_IDLE (all zero) and typedef lc3b_requester_id.
- One sub-module: pipeline_control_merge, a combinational OR-reduction of a granted request vector into one control word.

Test Plan:
- Requester 1 {active, barrier_IF_ID_reset, barrier_ID_EX_reset} plus requester 2 {active, stage_IF_stall}, no exclusive -> output has all three bits; grant = 0110; debug_stall_cycles +1.
- Requester 2 exclusive active with stage_IF_stall for 3 cycles, requester 0 non-exclusive active -> grant = 0100 each cycle; lock_valid = 1, lock_owner = 2 from cycle 2 on; requester 0's bits absent.
- Requesters 1 and 3 both exclusive at once -> owner 1. Requester 1 drops active in cycle k -> requester 3 is granted in cycle k and lock_owner = 3 after the edge.
- Merged barrier_ID_EX_reset with barrier_ID_EX_stall = 1 for one cycle, then requester gone, stall held 2 more cycles, then released -> barrier_ID_EX_reset output = 1 in the first unstalled cycle only.
- Assert reset while LOCKED with requests active -> output zero and grant = 0 that cycle; lock_valid = 0, counters = 0 the next cycle.
- Hold stage_IF_stall with CNT_WIDTH = 4 for 20 cycles -> debug_stall_cycles saturates at 15.
